// File: rtl/ir_pair_scheduler_if.sv
// Command, CTC and delay-timer signal bundle for ir_pair_scheduler.
// The slave modport is the scheduler's view; master is the upstream/peripheral side.
interface ir_pair_scheduler_if #(
    parameter int unsigned CTC_WIDTH   = 8,
    parameter int unsigned DELAY_WIDTH = 16
);
    logic                   cmd_valid_in;
    logic                   cmd_ready_out;
    logic [CTC_WIDTH-1:0]   cmd_carrier_in;
    logic [DELAY_WIDTH-1:0] cmd_on_in;
    logic [DELAY_WIDTH-1:0] cmd_off_in;
    logic                   cmd_last_in;
    logic                   abort_in;
    logic                   busy_out;
    logic                   done_out;
    logic                   ctc_enable_out;
    logic                   ctc_forced_out;
    logic                   ctc_wr_strobe_out;
    logic [CTC_WIDTH-1:0]   ctc_value_out;
    logic                   delay_enable_out;
    logic                   delay_start_strobe_out;
    logic [DELAY_WIDTH-1:0] delay_value_out;
    logic                   delay_busy_in;

    modport slave (
        input  cmd_valid_in, cmd_carrier_in, cmd_on_in, cmd_off_in, cmd_last_in,
        input  abort_in, delay_busy_in,
        output cmd_ready_out, busy_out, done_out,
        output ctc_enable_out, ctc_forced_out, ctc_wr_strobe_out, ctc_value_out,
        output delay_enable_out, delay_start_strobe_out, delay_value_out
    );

    modport master (
        output cmd_valid_in, cmd_carrier_in, cmd_on_in, cmd_off_in, cmd_last_in,
        output abort_in, delay_busy_in,
        input  cmd_ready_out, busy_out, done_out,
        input  ctc_enable_out, ctc_forced_out, ctc_wr_strobe_out, ctc_value_out,
        input  delay_enable_out, delay_start_strobe_out, delay_value_out
    );
endinterface

// File: rtl/ir_pair_scheduler.sv
// IR mark/space pair scheduler: a small command FIFO feeding the CTC carrier and delay timer.
// Define IR_CODE_GAP_EN to append a GAP_UNITS carrier-off gap after each last-flagged entry.
module ir_pair_scheduler #(
    parameter int unsigned            CTC_WIDTH   = 8,
    parameter int unsigned            DELAY_WIDTH = 16,
    parameter int unsigned            FIFO_DEPTH  = 4,
    parameter logic [DELAY_WIDTH-1:0] GAP_UNITS   = 16'd2000
) (
    input logic                clock_in,
    input logic                reset_n_in,
    ir_pair_scheduler_if.slave bus
);
    localparam int unsigned     PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned     CntW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    localparam logic [3:0] StIdle       = 4'd0;
    localparam logic [3:0] StLoad       = 4'd1;
    localparam logic [3:0] StMarkStart  = 4'd2;
    localparam logic [3:0] StMarkArm    = 4'd3;
    localparam logic [3:0] StMarkWait   = 4'd4;
    localparam logic [3:0] StSpaceStart = 4'd5;
    localparam logic [3:0] StSpaceArm   = 4'd6;
    localparam logic [3:0] StSpaceWait  = 4'd7;
    localparam logic [3:0] StFinish     = 4'd8;
`ifdef IR_CODE_GAP_EN
    localparam logic [3:0] StGapStart   = 4'd9;
    localparam logic [3:0] StGapArm     = 4'd10;
    localparam logic [3:0] StGapWait    = 4'd11;
`endif

    typedef struct packed {
        logic [CTC_WIDTH-1:0]   carrier;
        logic [DELAY_WIDTH-1:0] on_time;
        logic [DELAY_WIDTH-1:0] off_time;
        logic                   last;
    } entry_t;

    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [3:0]      state_q, state_d;
    entry_t          wk_q, wk_d;

    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ctc_en_q, ctc_en_d;
    logic                   ctc_wr_q, ctc_wr_d;
    logic [CTC_WIDTH-1:0]   ctc_val_q, ctc_val_d;
    logic                   dly_en_q, dly_en_d;
    logic                   dly_start_q, dly_start_d;
    logic [DELAY_WIDTH-1:0] dly_val_q, dly_val_d;

    logic push;
    logic pop;
    logic fifo_empty;

    always_comb begin
        // ready_q already reflects !full, so a push can never overflow
        push       = bus.cmd_valid_in && ready_q && !bus.abort_in;
        fifo_empty = (count_q == '0);
        pop        = 1'b0;

        state_d     = state_q;
        wk_d        = wk_q;
        done_d      = 1'b0;
        ctc_en_d    = ctc_en_q;
        ctc_wr_d    = 1'b0;
        ctc_val_d   = ctc_val_q;
        dly_en_d    = dly_en_q;
        dly_start_d = 1'b0;
        dly_val_d   = dly_val_q;

        case (state_q)
            StIdle: begin
                ctc_en_d = 1'b0;
                dly_en_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ctc_wr_d  = 1'b1;
                ctc_val_d = wk_q.carrier;
                if (wk_q.on_time != '0) begin
                    state_d = StMarkStart;
                end else if (wk_q.off_time != '0) begin
                    state_d = StSpaceStart;
                end else begin
                    state_d = StFinish;
                end
            end
            StMarkStart: begin
                ctc_en_d    = 1'b1;
                dly_en_d    = 1'b1;
                dly_start_d = 1'b1;
                dly_val_d   = wk_q.on_time;
                state_d     = StMarkArm;
            end
            // Timer has not yet seen the start strobe, so its busy flag is stale here
            StMarkArm: begin
                state_d = StMarkWait;
            end
            StMarkWait: begin
                ctc_en_d = 1'b1;
                if (!bus.delay_busy_in) begin
                    ctc_en_d = 1'b0;
                    state_d  = (wk_q.off_time != '0) ? StSpaceStart : StFinish;
                end
            end
            StSpaceStart: begin
                ctc_en_d    = 1'b0;
                dly_en_d    = 1'b1;
                dly_start_d = 1'b1;
                dly_val_d   = wk_q.off_time;
                state_d     = StSpaceArm;
            end
            StSpaceArm: begin
                state_d = StSpaceWait;
            end
            StSpaceWait: begin
                if (!bus.delay_busy_in) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
`ifdef IR_CODE_GAP_EN
                if (wk_q.last) begin
                    state_d = StGapStart;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
`else
                done_d = wk_q.last;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
`endif
            end
`ifdef IR_CODE_GAP_EN
            StGapStart: begin
                ctc_en_d    = 1'b0;
                dly_en_d    = 1'b1;
                dly_start_d = 1'b1;
                dly_val_d   = GAP_UNITS;
                state_d     = StGapArm;
            end
            StGapArm: begin
                state_d = StGapWait;
            end
            StGapWait: begin
                if (!bus.delay_busy_in) begin
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{carrier:  bus.cmd_carrier_in,
                                on_time:  bus.cmd_on_in,
                                off_time: bus.cmd_off_in,
                                last:     bus.cmd_last_in};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            wk_d     = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Abort overrides everything above, including a coincident push
        if (bus.abort_in) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            state_d     = StIdle;
            done_d      = 1'b0;
            ctc_en_d    = 1'b0;
            ctc_wr_d    = 1'b0;
            dly_en_d    = 1'b0;
            dly_start_d = 1'b0;
        end

        ready_d = (count_d != FullCnt);
        busy_d  = (count_d != '0) || (state_d != StIdle);
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            wk_q        <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ctc_en_q    <= 1'b0;
            ctc_wr_q    <= 1'b0;
            ctc_val_q   <= '0;
            dly_en_q    <= 1'b0;
            dly_start_q <= 1'b0;
            dly_val_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            wk_q        <= wk_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ctc_en_q    <= ctc_en_d;
            ctc_wr_q    <= ctc_wr_d;
            ctc_val_q   <= ctc_val_d;
            dly_en_q    <= dly_en_d;
            dly_start_q <= dly_start_d;
            dly_val_q   <= dly_val_d;
        end
    end

    assign bus.cmd_ready_out          = ready_q;
    assign bus.busy_out               = busy_q;
    assign bus.done_out               = done_q;
    assign bus.ctc_enable_out         = ctc_en_q;
    assign bus.ctc_forced_out         = 1'b0;
    assign bus.ctc_wr_strobe_out      = ctc_wr_q;
    assign bus.ctc_value_out          = ctc_val_q;
    assign bus.delay_enable_out       = dly_en_q;
    assign bus.delay_start_strobe_out = dly_start_q;
    assign bus.delay_value_out        = dly_val_q;

endmodule

// File: tb/tb_ir_pair_scheduler.sv
// Scoreboard bench for ir_pair_scheduler: stimulus queues expected carrier/delay/done events,
// a negedge monitor pops and compares them; a small counter models the delay timer.
module tb_ir_pair_scheduler;
    localparam int unsigned CtcW    = 8;
    localparam int unsigned DlyW    = 16;
    localparam int          KStrobe = 0;
    localparam int          KMark   = 1;
    localparam int          KSpace  = 2;
    localparam int          KDone   = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ir_pair_scheduler_if #(.CTC_WIDTH(CtcW), .DELAY_WIDTH(DlyW)) bus ();

    ir_pair_scheduler #(
        .CTC_WIDTH  (CtcW),
        .DELAY_WIDTH(DlyW),
        .FIFO_DEPTH (4),
        .GAP_UNITS  (16'd2000)
    ) dut (
        .clock_in  (clk),
        .reset_n_in(rst_n),
        .bus       (bus)
    );

    // Delay timer: loads on strobe, stays busy while the count is non-zero
    logic [DlyW-1:0] tmr_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmr_q <= '0;
        else if (!bus.delay_enable_out) tmr_q <= '0;
        else if (bus.delay_start_strobe_out) tmr_q <= bus.delay_value_out;
        else if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
    end
    assign bus.delay_busy_in = (tmr_q != '0);

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  stalls = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input string name, input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got unexpected event kind %0d value %0d, expected none",
                     name, kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ctc_wr_strobe_out) observe("ctc_strobe", KStrobe, int'(bus.ctc_value_out));
            if (bus.delay_start_strobe_out)
                observe("delay_start", bus.ctc_enable_out ? KMark : KSpace,
                        int'(bus.delay_value_out));
            if (bus.done_out) observe("done", KDone, 0);
        end
    end

    task automatic push(input int carrier, input int on_t, input int off_t, input bit last);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid_in   = 1'b1;
        bus.cmd_carrier_in = CtcW'(carrier);
        bus.cmd_on_in      = DlyW'(on_t);
        bus.cmd_off_in     = DlyW'(off_t);
        bus.cmd_last_in    = last;
        while (!bus.cmd_ready_out && n < 200) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready_out) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready_out got 0, expected 1");
        end else begin
            expect_ev(KStrobe, carrier);
            if (on_t != 0) expect_ev(KMark, on_t);
            if (off_t != 0) expect_ev(KSpace, off_t);
            if (last) begin
`ifdef IR_CODE_GAP_EN
                expect_ev(KSpace, 2000);
`endif
                expect_ev(KDone, 0);
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.busy_out || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, int'(bus.busy_out), 0);
        check({name, "_pending_events"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_ready"}, int'(bus.cmd_ready_out), 0);
        check({p, "_busy"}, int'(bus.busy_out), 0);
        check({p, "_done"}, int'(bus.done_out), 0);
        check({p, "_ctc_en"}, int'(bus.ctc_enable_out), 0);
        check({p, "_ctc_forced"}, int'(bus.ctc_forced_out), 0);
        check({p, "_ctc_wr"}, int'(bus.ctc_wr_strobe_out), 0);
        check({p, "_ctc_val"}, int'(bus.ctc_value_out), 0);
        check({p, "_dly_en"}, int'(bus.delay_enable_out), 0);
        check({p, "_dly_start"}, int'(bus.delay_start_strobe_out), 0);
        check({p, "_dly_val"}, int'(bus.delay_value_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        bus.cmd_valid_in   = 1'b0;
        bus.cmd_carrier_in = '0;
        bus.cmd_on_in      = '0;
        bus.cmd_off_in     = '0;
        bus.cmd_last_in    = 1'b0;
        bus.abort_in       = 1'b0;

        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", int'(bus.cmd_ready_out), 0);
        @(posedge clk);
        #1 check("ready_after_edge", int'(bus.cmd_ready_out), 1);

        // Single entry: carrier 26, mark 10, space 20, last
        push(26, 10, 20, 1'b1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.ctc_enable_out) begin
                lat = i;
                break;
            end
        end
        check("mark_latency_edges", lat, 3);
        wait_idle("single", 1000);

        // Burst of six into a four-deep FIFO
        stalls = 0;
        for (int i = 0; i < 5; i++) push(30 + i, 3 + i, 2 + i, 1'b0);
        check("ready_when_full", int'(bus.cmd_ready_out), 0);
        push(35, 8, 7, 1'b1);
        check("burst_stalled", int'(stalls > 0), 1);
        wait_idle("burst", 2000);

        // Zero-duration marks and spaces
        push(40, 0, 5, 1'b0);
        push(41, 7, 0, 1'b0);
        push(42, 0, 0, 1'b1);
        wait_idle("zero_dur", 1000);

        // Abort during a long mark with three entries queued
        push(50, 30, 30, 1'b0);
        push(51, 5, 5, 1'b0);
        push(52, 5, 5, 1'b0);
        push(53, 5, 5, 1'b1);
        n = 0;
        while (!bus.ctc_enable_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_mark_running", int'(bus.ctc_enable_out), 1);
        repeat (5) @(negedge clk);
        exp_q.delete();
        bus.abort_in       = 1'b1;
        bus.cmd_valid_in   = 1'b1;
        bus.cmd_carrier_in = 8'd99;
        bus.cmd_on_in      = 16'd9;
        bus.cmd_off_in     = 16'd9;
        bus.cmd_last_in    = 1'b1;
        @(posedge clk);
        #1;
        bus.abort_in     = 1'b0;
        bus.cmd_valid_in = 1'b0;
        check("abort_ctc_en", int'(bus.ctc_enable_out), 0);
        check("abort_dly_en", int'(bus.delay_enable_out), 0);
        check("abort_busy", int'(bus.busy_out), 0);
        check("abort_ready", int'(bus.cmd_ready_out), 1);
        repeat (60) @(negedge clk);
        check("abort_still_idle", int'(bus.busy_out), 0);

        // Asynchronous reset in the middle of a space
        push(60, 4, 40, 1'b1);
        n = 0;
        while (!bus.ctc_enable_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.ctc_enable_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_rst", int'(bus.cmd_ready_out), 1);
        push(70, 5, 6, 1'b1);
        wait_idle("post_reset", 1000);

        // Last entry with short mark/space; includes the inter-code gap when enabled
        push(80, 4, 4, 1'b1);
        wait_idle("gap_entry", 4000);
        check("ctc_forced_end", int'(bus.ctc_forced_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
